// File: rtl/mac_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac_job_sequencer
// Function : Runs N-term multiply-accumulate jobs on an external MAC datapath,
//            then returns the accumulator with a signed threshold flag.
// Revision : 1.0  initial release
// ============================================================================

module mac_job_sequencer #(
   parameter int DW      = 16,
   parameter int AW      = 40,
   parameter int TW      = 32,
   parameter int LEN_W   = 8,
   parameter int MAC_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [TW-1:0]    threshold,
   output logic             busy,
   output logic             err_len,
   input  logic             op_valid,
   input  logic [DW-1:0]    op_a,
   input  logic [DW-1:0]    op_b,
   output logic             op_ready,
   output logic             mac_ce,
   output logic             mac_sload,
   output logic [DW-1:0]    mac_a,
   output logic [DW-1:0]    mac_b,
   input  logic [AW-1:0]    mac_accum,
   output logic             res_valid,
   output logic [AW-1:0]    res_data,
   output logic             res_over
);

   // Drain counter must reach MAC_LAT, so it needs clog2(MAC_LAT+1) bits.
   localparam int DCW = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state;
   state_t             state_next;

   logic [LEN_W-1:0]   len_q;
   logic [TW-1:0]      thr_q;
   logic [LEN_W-1:0]   cnt;
   logic               first;
   logic [DCW-1:0]     drain_cnt;

   logic               job_accept;
   logic               len_reject;
   logic               transfer;
   logic               last_beat;
   logic               capture;
   logic signed [AW-1:0] thr_ext;

   assign busy    = (state != S_IDLE);
   assign thr_ext = AW'($signed(thr_q));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      job_accept = 1'b0;
      len_reject = 1'b0;
      op_ready   = 1'b0;
      transfer   = 1'b0;
      last_beat  = 1'b0;
      capture    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  job_accept = 1'b1;
                  state_next = S_ACCUM;
               end else begin
                  len_reject = 1'b1;
               end
            end
         end
         S_ACCUM: begin
            op_ready  = (cnt < len_q);
            transfer  = op_valid & op_ready;
            last_beat = transfer && (cnt == len_q - 1'b1);
            if (last_beat) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // The first DRAIN cycle carries the last beat's mac_ce, so the
            // accumulator is valid once MAC_LAT further cycles have passed.
            if (drain_cnt == DCW'(MAC_LAT)) begin
               capture    = 1'b1;
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len_q     <= '0;
         thr_q     <= '0;
         cnt       <= '0;
         first     <= 1'b0;
         drain_cnt <= '0;
         err_len   <= 1'b0;
         mac_ce    <= 1'b0;
         mac_sload <= 1'b0;
         mac_a     <= '0;
         mac_b     <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_over  <= 1'b0;
      end else begin
         err_len   <= len_reject;
         mac_ce    <= transfer;
         mac_sload <= transfer & first;
         res_valid <= capture;

         if (job_accept) begin
            len_q <= len;
            thr_q <= threshold;
            cnt   <= '0;
            first <= 1'b1;
         end

         if (transfer) begin
            mac_a <= op_a;
            mac_b <= op_b;
            first <= 1'b0;
            cnt   <= cnt + 1'b1;
         end

         if (last_beat) begin
            drain_cnt <= '0;
         end else if (state == S_DRAIN) begin
            drain_cnt <= drain_cnt + 1'b1;
         end

         if (capture) begin
            res_data <= mac_accum;
            res_over <= ($signed(mac_accum) > thr_ext);
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/mac_job_sequencer.md
Name: mac_job_sequencer

Overview:
- Sequences the shared MAC datapath (ce/sload/var_a/var_b, accumulator out) for N-term multiply-accumulate jobs.
- A requester issues start+len+threshold, then streams operand pairs over valid/ready.
- The block drives the MAC enables, waits out the MAC pipeline latency, and captures the accumulator.
- It returns the result with a threshold-crossing flag; it sits between the job source and mac_top / the tcb MAC variants.

Parameters:
- DW, 16, operand width (var_a/var_b).
- AW, 40, accumulator width.
- TW, 32, threshold width (constant_threshold).
- LEN_W, 8, job length counter width; max job length 2^LEN_W-1.
- MAC_LAT, 1, cycles from a cycle with mac_ce=1 until mac_accum reflects that beat (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request, sampled in IDLE only.
- len  in  LEN_W  number of operand pairs in the job.
- threshold  in  TW  signed compare threshold, latched at start.
- busy  out  1  high from accepted start until res_valid cycle inclusive.
- err_len  out  1  one-cycle pulse: start with len==0 rejected.
- op_valid  in  1  operand pair valid.
- op_a  in  DW  operand a.
- op_b  in  DW  operand b.
- op_ready  out  1  sequencer accepts operand pair.
- mac_ce  out  1  MAC clock enable (registered).
- mac_sload  out  1  MAC load-instead-of-accumulate (registered).
- mac_a  out  DW  to MAC var_a (registered).
- mac_b  out  DW  to MAC var_b (registered).
- mac_accum  in  AW  MAC accumulator output.
- res_valid  out  1  one-cycle result strobe.
- res_data  out  AW  captured accumulator, held until next res_valid.
- res_over  out  1  res_data > sign-extended threshold (signed), held with res_data.

Behaviour:
- Reset: state=IDLE; busy, err_len, op_ready, mac_ce, mac_sload, res_valid, res_over = 0; mac_a, mac_b, res_data = 0; counters = 0. Reset mid-job abandons the job with no res_valid; the next start after rst deasserts begins clean.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - start & len!=0: latch len and threshold, cnt=0, first=1, go to ACCUM.
  - start & len==0: err_len=1 next cycle, stay IDLE.
- ACCUM:
  - op_ready = (cnt < len_latched), combinational from state/cnt.
  - Transfer = op_valid & op_ready. On transfer: next cycle mac_ce=1, mac_a/mac_b = op_a/op_b, mac_sload = first; then first=0, cnt++.
  - No transfer: next cycle mac_ce=0, mac_sload=0; mac_a/mac_b hold.
  - Transfer with cnt==len-1: go to DRAIN, drain counter = 0.
- DRAIN:
  - op_ready=0.
  - Last beat's mac_ce is high in the first DRAIN cycle; mac_ce=0 thereafter.
  - Count MAC_LAT cycles after the last mac_ce cycle, then sample mac_accum into res_data and compute res_over. Go to DONE.
- DONE: res_valid=1 for exactly one cycle, busy=1 in this cycle, then IDLE (busy=0 next cycle).
- Timing: if the last transfer occurs in cycle T, mac_ce=1 in T+1, mac_accum is sampled at the end of cycle T+1+MAC_LAT, and res_valid is high in T+2+MAC_LAT.
- Compare: signed; threshold sign-extended TW→AW; equality gives res_over=0.
- start while busy: ignored, no error. op_valid outside ACCUM: ignored, no transfer.
- len=1: a single beat with mac_sload=1; result = a*b.
- cnt never exceeds len_latched; no wrap.

Test Plan (bench uses a behavioural MAC model with latency MAC_LAT; the sload beat loads the product):
- rst 3 cycles -> all outputs 0, busy=0; mid-reset start ignored.
- start, len=4, threshold=2147483647, four pairs (1,29) back-to-back -> mac_sload high only on beat 1; res_data=116, res_over=0; res_valid exactly at T+2+MAC_LAT.
- Same job with threshold=100 -> res_data=116, res_over=1; threshold=116 -> res_over=0.
- len=3 with op_valid gaps (valid, idle x2, valid, idle, valid) operands (2,3),(4,5),(-1,7) -> mac_ce pulses only on transfers; res_data=19.
- start with len=0 -> err_len one cycle, busy stays 0; start during busy -> ignored, first job result unaffected.
- rst asserted after 2 of 5 beats -> no res_valid; a new len=1 job (0,29) afterwards -> mac_sload=1, res_data=0, res_over=0 with threshold=0.
